// File: rtl/tx_word_scheduler_if.sv
// Producer-side and UART-TX-side signals of the word scheduler, grouped as one bus.
// The master modport is the side that pushes words and reports tx_done.
// The slave modport is the scheduler itself.
interface tx_word_scheduler_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [15:0]   wr_data;
  logic          tx_done;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          busy;
  logic          overflow;
  logic [7:0]    words_sent;

  modport master (
    output wr_en, wr_data, tx_done,
    input  tx_start, tx_data, full, empty, count, busy, overflow, words_sent
  );

  modport slave (
    input  wr_en, wr_data, tx_done,
    output tx_start, tx_data, full, empty, count, busy, overflow, words_sent
  );
endinterface

// File: rtl/tx_word_scheduler.sv
// Queues 16-bit words in a small FIFO and sends each one as two bytes
// through the UART TX start/done handshake.
// The next word is issued straight from WAIT_LO, so frames go out back-to-back.
module tx_word_scheduler #(
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic             clk,
  input logic             rst,
  tx_word_scheduler_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    SEND_HI,
    WAIT_HI,
    SEND_LO,
    WAIT_LO
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   hold_q, hold_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    words_sent_q, words_sent_d;

  logic          full;
  logic          push;
  logic          pop;
  logic          word_done;
  logic [15:0]   head_word;

  function automatic logic [7:0] first_byte(input logic [15:0] w);
    return MSB_FIRST ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [7:0] second_byte(input logic [15:0] w);
    return MSB_FIRST ? w[7:0] : w[15:8];
  endfunction

  // full uses the pre-edge count, so a push into a full FIFO is dropped even if a pop happens on the same edge.
  assign full      = (count_q == CW'(DEPTH));
  assign push      = bus.wr_en && !full;
  assign word_done = (state_q == WAIT_LO) && bus.tx_done;
  assign pop       = (count_q != '0) && ((state_q == IDLE) || word_done);
  assign head_word = mem_q[rd_ptr_q];

  // Register all state; a synchronous reset clears everything except the word storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hold_q       <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      overflow_q   <= 1'b0;
      words_sent_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      hold_q       <= hold_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      overflow_q   <= overflow_d;
      words_sent_q <= words_sent_d;
    end
  end

  // Word storage needs no reset: count gates every read, so stale entries are never popped.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  // Next-state logic; tx_done counts only in the two WAIT states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count_q != '0) state_d = SEND_HI;
      SEND_HI: state_d = WAIT_HI;
      WAIT_HI: if (bus.tx_done) state_d = SEND_LO;
      SEND_LO: state_d = WAIT_LO;
      WAIT_LO: if (bus.tx_done) state_d = (count_q != '0) ? SEND_HI : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping, the start pulse and byte selection, and the status counters.
  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d      = count_q;
    hold_d       = hold_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    overflow_d   = overflow_q | (bus.wr_en & full);
    words_sent_d = words_sent_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (pop) begin
      hold_d     = head_word;
      tx_start_d = 1'b1;
      tx_data_d  = first_byte(head_word);
    end

    if ((state_q == WAIT_HI) && bus.tx_done) begin
      tx_start_d = 1'b1;
      tx_data_d  = second_byte(hold_q);
    end

    if (word_done) begin
      words_sent_d = words_sent_q + 8'd1;
    end
  end

  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.full       = full;
  assign bus.empty      = (count_q == '0);
  assign bus.count      = count_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.overflow   = overflow_q;
  assign bus.words_sent = words_sent_q;
endmodule

// File: tb/tb_tx_word_scheduler.sv
// Directed testbench for tx_word_scheduler: one MSB-first and one LSB-first instance.
// Inputs change and outputs are sampled on the falling edge.
module tb_tx_word_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  tx_word_scheduler_if #(.DEPTH(4)) bus_a ();
  tx_word_scheduler_if #(.DEPTH(4)) bus_b ();

  tx_word_scheduler #(.DEPTH(4), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  tx_word_scheduler #(.DEPTH(4), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Advance one rising edge, then return on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push_a(input logic [15:0] w);
    bus_a.wr_en   = 1'b1;
    bus_a.wr_data = w;
    step();
    bus_a.wr_en   = 1'b0;
  endtask

  task automatic pulse_done_a();
    bus_a.tx_done = 1'b1;
    step();
    bus_a.tx_done = 1'b0;
  endtask

  task automatic pulse_done_b();
    bus_b.tx_done = 1'b1;
    step();
    bus_b.tx_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus_a.tx_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_start: got %b expected 0", bus_a.tx_start); end
    checks++; if (bus_a.tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data: got %h expected 00", bus_a.tx_data); end
    checks++; if (bus_a.full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", bus_a.full); end
    checks++; if (bus_a.empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", bus_a.empty); end
    checks++; if (bus_a.count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", bus_a.count); end
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus_a.busy); end
    checks++; if (bus_a.overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", bus_a.overflow); end
    checks++; if (bus_a.words_sent !== 8'd0) begin errors++; $display("[TB] FAIL reset_words_sent: got %0d expected 0", bus_a.words_sent); end
    checks++; if (bus_b.empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_b_empty: got %b expected 1", bus_b.empty); end
    checks++; if (bus_b.tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_b_tx_data: got %h expected 00", bus_b.tx_data); end
  endtask

  task automatic test_single_word();
    do_reset();
    push_a(16'hA55A);
    checks++; if (bus_a.count !== 3'd1) begin errors++; $display("[TB] FAIL single_count_after_push: got %0d expected 1", bus_a.count); end
    checks++; if (bus_a.tx_start !== 1'b0) begin errors++; $display("[TB] FAIL single_no_fallthrough: got %b expected 0", bus_a.tx_start); end
    step();
    checks++; if ({bus_a.tx_start, bus_a.tx_data} !== {1'b1, 8'hA5}) begin errors++; $display("[TB] FAIL single_first_byte: got start=%b data=%h expected start=1 data=a5", bus_a.tx_start, bus_a.tx_data); end
    checks++; if (bus_a.count !== 3'd0) begin errors++; $display("[TB] FAIL single_count_after_pop: got %0d expected 0", bus_a.count); end
    checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b expected 1", bus_a.busy); end
    step();
    checks++; if ({bus_a.tx_start, bus_a.tx_data} !== {1'b0, 8'hA5}) begin errors++; $display("[TB] FAIL single_pulse_end: got start=%b data=%h expected start=0 data=a5", bus_a.tx_start, bus_a.tx_data); end
    repeat (17) step();
    pulse_done_a();
    checks++; if ({bus_a.tx_start, bus_a.tx_data} !== {1'b1, 8'h5A}) begin errors++; $display("[TB] FAIL single_second_byte: got start=%b data=%h expected start=1 data=5a", bus_a.tx_start, bus_a.tx_data); end
    step();
    checks++; if (bus_a.tx_start !== 1'b0) begin errors++; $display("[TB] FAIL single_second_pulse_end: got %b expected 0", bus_a.tx_start); end
    repeat (5) step();
    pulse_done_a();
    checks++; if (bus_a.words_sent !== 8'd1) begin errors++; $display("[TB] FAIL single_words_sent: got %0d expected 1", bus_a.words_sent); end
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle: got busy=%b expected 0", bus_a.busy); end
    checks++; if (bus_a.empty !== 1'b1) begin errors++; $display("[TB] FAIL single_empty: got %b expected 1", bus_a.empty); end
  endtask

  task automatic test_lsb_first();
    do_reset();
    bus_b.wr_en   = 1'b1;
    bus_b.wr_data = 16'h1234;
    step();
    bus_b.wr_en   = 1'b0;
    step();
    checks++; if ({bus_b.tx_start, bus_b.tx_data} !== {1'b1, 8'h34}) begin errors++; $display("[TB] FAIL lsb_first_byte: got start=%b data=%h expected start=1 data=34", bus_b.tx_start, bus_b.tx_data); end
    repeat (4) step();
    pulse_done_b();
    checks++; if ({bus_b.tx_start, bus_b.tx_data} !== {1'b1, 8'h12}) begin errors++; $display("[TB] FAIL lsb_second_byte: got start=%b data=%h expected start=1 data=12", bus_b.tx_start, bus_b.tx_data); end
    repeat (4) step();
    pulse_done_b();
    checks++; if (bus_b.words_sent !== 8'd1) begin errors++; $display("[TB] FAIL lsb_words_sent: got %0d expected 1", bus_b.words_sent); end
    checks++; if (bus_b.busy !== 1'b0) begin errors++; $display("[TB] FAIL lsb_idle: got busy=%b expected 0", bus_b.busy); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) push_a(16'(i));
    checks++; if (bus_a.count !== 3'd4) begin errors++; $display("[TB] FAIL fill_count: got %0d expected 4", bus_a.count); end
    checks++; if (bus_a.full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full: got %b expected 1", bus_a.full); end
    checks++; if (bus_a.overflow !== 1'b0) begin errors++; $display("[TB] FAIL fill_no_overflow: got %b expected 0", bus_a.overflow); end
    push_a(16'h0006);
    checks++; if (bus_a.overflow !== 1'b1) begin errors++; $display("[TB] FAIL fill_overflow_set: got %b expected 1", bus_a.overflow); end
    checks++; if (bus_a.count !== 3'd4) begin errors++; $display("[TB] FAIL fill_dropped_count: got %0d expected 4", bus_a.count); end
    for (int k = 1; k <= 5; k++) begin
      pulse_done_a();
      checks++; if ({bus_a.tx_start, bus_a.tx_data} !== {1'b1, 8'(k)}) begin errors++; $display("[TB] FAIL fill_lo_byte_%0d: got start=%b data=%h expected start=1 data=%h", k, bus_a.tx_start, bus_a.tx_data, 8'(k)); end
      step();
      pulse_done_a();
      if (k < 5) begin
        checks++; if ({bus_a.tx_start, bus_a.tx_data} !== {1'b1, 8'h00}) begin errors++; $display("[TB] FAIL fill_hi_byte_%0d: got start=%b data=%h expected start=1 data=00", k + 1, bus_a.tx_start, bus_a.tx_data); end
      end
      step();
    end
    checks++; if (bus_a.words_sent !== 8'd5) begin errors++; $display("[TB] FAIL fill_words_sent: got %0d expected 5", bus_a.words_sent); end
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("[TB] FAIL fill_idle_after_drain: got busy=%b expected 0", bus_a.busy); end
    checks++; if (bus_a.empty !== 1'b1) begin errors++; $display("[TB] FAIL fill_empty: got %b expected 1", bus_a.empty); end
    checks++; if (bus_a.overflow !== 1'b1) begin errors++; $display("[TB] FAIL fill_overflow_sticky: got %b expected 1", bus_a.overflow); end
  endtask

  task automatic test_reset_mid();
    push_a(16'h0A0B);
    push_a(16'h0C0D);
    push_a(16'h0E0F);
    checks++; if ({bus_a.busy, bus_a.count} !== {1'b1, 3'd2}) begin errors++; $display("[TB] FAIL mid_setup: got busy=%b count=%0d expected busy=1 count=2", bus_a.busy, bus_a.count); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus_a.count !== 3'd0) begin errors++; $display("[TB] FAIL mid_count: got %0d expected 0", bus_a.count); end
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %b expected 0", bus_a.busy); end
    checks++; if (bus_a.tx_start !== 1'b0) begin errors++; $display("[TB] FAIL mid_tx_start: got %b expected 0", bus_a.tx_start); end
    checks++; if (bus_a.words_sent !== 8'd0) begin errors++; $display("[TB] FAIL mid_words_sent: got %0d expected 0", bus_a.words_sent); end
    checks++; if (bus_a.overflow !== 1'b0) begin errors++; $display("[TB] FAIL mid_overflow: got %b expected 0", bus_a.overflow); end
    checks++; if (bus_a.tx_data !== 8'h00) begin errors++; $display("[TB] FAIL mid_tx_data: got %h expected 00", bus_a.tx_data); end
    push_a(16'hBEEF);
    step();
    checks++; if ({bus_a.tx_start, bus_a.tx_data} !== {1'b1, 8'hBE}) begin errors++; $display("[TB] FAIL mid_after_hi: got start=%b data=%h expected start=1 data=be", bus_a.tx_start, bus_a.tx_data); end
    step();
    pulse_done_a();
    checks++; if ({bus_a.tx_start, bus_a.tx_data} !== {1'b1, 8'hEF}) begin errors++; $display("[TB] FAIL mid_after_lo: got start=%b data=%h expected start=1 data=ef", bus_a.tx_start, bus_a.tx_data); end
    step();
    pulse_done_a();
    checks++; if ({bus_a.busy, bus_a.words_sent} !== {1'b0, 8'd1}) begin errors++; $display("[TB] FAIL mid_after_done: got busy=%b words_sent=%0d expected busy=0 words_sent=1", bus_a.busy, bus_a.words_sent); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_bytes [6];
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    do_reset();
    push_a(16'h1122);
    push_a(16'h3344);
    push_a(16'h5566);
    checks++; if ({bus_a.tx_start, bus_a.tx_data, bus_a.count} !== {1'b0, exp_bytes[0], 3'd2}) begin errors++; $display("[TB] FAIL b2b_first: got start=%b data=%h count=%0d expected start=0 data=11 count=2", bus_a.tx_start, bus_a.tx_data, bus_a.count); end
    for (int i = 1; i < 6; i++) begin
      pulse_done_a();
      checks++; if ({bus_a.tx_start, bus_a.tx_data} !== {1'b1, exp_bytes[i]}) begin errors++; $display("[TB] FAIL b2b_byte_%0d: got start=%b data=%h expected start=1 data=%h", i, bus_a.tx_start, bus_a.tx_data, exp_bytes[i]); end
      step();
    end
    pulse_done_a();
    checks++; if (bus_a.words_sent !== 8'd3) begin errors++; $display("[TB] FAIL b2b_words_sent: got %0d expected 3", bus_a.words_sent); end
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: got busy=%b expected 0", bus_a.busy); end
  endtask

  task automatic test_spurious_done();
    do_reset();
    bus_a.tx_done = 1'b1;
    step();
    step();
    bus_a.tx_done = 1'b0;
    checks++; if ({bus_a.busy, bus_a.tx_start, bus_a.words_sent} !== {1'b0, 1'b0, 8'd0}) begin errors++; $display("[TB] FAIL spur_idle: got busy=%b start=%b words_sent=%0d expected 0 0 0", bus_a.busy, bus_a.tx_start, bus_a.words_sent); end
    push_a(16'hC33C);
    step();
    checks++; if ({bus_a.tx_start, bus_a.tx_data} !== {1'b1, 8'hC3}) begin errors++; $display("[TB] FAIL spur_start: got start=%b data=%h expected start=1 data=c3", bus_a.tx_start, bus_a.tx_data); end
    bus_a.tx_done = 1'b1;
    step();
    bus_a.tx_done = 1'b0;
    checks++; if ({bus_a.busy, bus_a.tx_start} !== {1'b1, 1'b0}) begin errors++; $display("[TB] FAIL spur_during_start: got busy=%b start=%b expected busy=1 start=0", bus_a.busy, bus_a.tx_start); end
    repeat (3) step();
    checks++; if ({bus_a.tx_start, bus_a.tx_data, bus_a.words_sent} !== {1'b0, 8'hC3, 8'd0}) begin errors++; $display("[TB] FAIL spur_still_waiting: got start=%b data=%h words_sent=%0d expected start=0 data=c3 words_sent=0", bus_a.tx_start, bus_a.tx_data, bus_a.words_sent); end
    pulse_done_a();
    checks++; if ({bus_a.tx_start, bus_a.tx_data} !== {1'b1, 8'h3C}) begin errors++; $display("[TB] FAIL spur_lo_byte: got start=%b data=%h expected start=1 data=3c", bus_a.tx_start, bus_a.tx_data); end
    step();
    pulse_done_a();
    checks++; if ({bus_a.busy, bus_a.words_sent} !== {1'b0, 8'd1}) begin errors++; $display("[TB] FAIL spur_done: got busy=%b words_sent=%0d expected busy=0 words_sent=1", bus_a.busy, bus_a.words_sent); end
  endtask

  // Run every scenario in order, then print the summary.
  initial begin
    bus_a.wr_en   = 1'b0;
    bus_a.wr_data = 16'h0000;
    bus_a.tx_done = 1'b0;
    bus_b.wr_en   = 1'b0;
    bus_b.wr_data = 16'h0000;
    bus_b.tx_done = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_word();
    test_lsb_first();
    test_fill_overflow();
    test_reset_mid();
    test_back_to_back();
    test_spurious_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
